// File: rtl/bit_divider_pkg.sv
// Purpose: shared definitions for the small-arithmetic divider (state encoding, width, divide-by-zero result).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bit_divider_pkg;

  // Operand width the divider is built and verified at.
  localparam int DIV_WIDTH = 4;

  // Quotient reported when the divisor is zero: all ones.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/bit_subtractor.sv
// Purpose: W-bit ripple-borrow subtractor, o_diff = i_a - i_b - i_bin, o_bout = final borrow.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
// Ports: i_a/i_b minuend/subtrahend, i_bin borrow-in, o_diff difference, o_bout borrow-out.
module bit_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_diff,
  output logic         o_bout
);

  logic [W:0] w_borrow;

  assign w_borrow[0] = i_bin;

  for (genvar i = 0; i < W; i++) begin : g_fs
    assign o_diff[i]       = i_a[i] ^ i_b[i] ^ w_borrow[i];
    assign w_borrow[i+1]   = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_borrow[i]);
  end

  assign o_bout = w_borrow[W];

endmodule

// File: rtl/bit_divider.sv
// Purpose: sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done WIDTH+1 cycles after an accepted start (1 cycle for a zero divisor).
// Backpressure: start is only taken in IDLE; requests while busy or done are dropped, not queued.
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_start/i_dividend/i_divisor request;
//        o_quotient/o_remainder/o_div_by_zero registered results; o_busy while iterating; o_done 1-cycle strobe.
module bit_divider
  import bit_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] L_DBZ_Q = {WIDTH{DBZ_QUOTIENT[0]}};

  div_state_t r_state;
  div_state_t w_state_nxt;

  logic [WIDTH:0]   r_a;          // partial remainder, one guard bit wide
  logic [WIDTH-1:0] r_q;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_a_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_borrow;
  logic             w_last;
  logic             w_accept;
  logic             w_zero_div;
  logic             w_busy;
  logic             w_done;

  // One restoring step: bring in the next dividend bit, then try to take D out.
  assign w_a_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};

  bit_subtractor #(
    .W(WIDTH + 1)
  ) u_sub (
    .i_a   (w_a_shift),
    .i_b   ({1'b0, r_d}),
    .i_bin (1'b0),
    .o_diff(w_diff),
    .o_bout(w_borrow)
  );

  // A borrow means D did not fit: keep the shifted value and shift in a 0.
  assign w_a_nxt    = w_borrow ? w_a_shift : w_diff;
  assign w_q_nxt    = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last     = (r_cnt == L_LAST);
  assign w_accept   = (r_state == ST_IDLE) && i_start;
  assign w_zero_div = (i_divisor == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = w_zero_div ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        // Zero divisor short-circuits straight to DONE with a fixed answer.
        r_quotient  <= L_DBZ_Q;
        r_remainder <= i_dividend;
        r_dbz       <= 1'b1;
      end else begin
        r_a   <= '0;
        r_q   <= i_dividend;
        r_d   <= i_divisor;
        r_cnt <= '0;
        r_dbz <= 1'b0;
      end
    end else if (r_state == ST_CALC) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quotient  <= w_q_nxt;
        r_remainder <= w_a_nxt[WIDTH-1:0];
      end
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_dbz;
  assign o_busy        = w_busy;
  assign o_done        = w_done;

endmodule
